// File: rtl/rf_write_buffer.sv
// rf_write_buffer: collects writeback results from the in-order pipeline (A)
// and the multiply unit (B) into a small in-order FIFO. The FIFO drains to the
// register file write port at one entry per cycle. Two bypass ports let decode
// read results that are still queued.
module rf_write_buffer #(
  parameter  int XLEN    = 32,
  parameter  int REG_NUM = 32,
  parameter  int DEPTH   = 4,
  localparam int AW      = $clog2(REG_NUM),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  // producer A: in-order pipeline writeback
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_data,
  // producer B: multiply unit (priority over A)
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_rd,
  input  logic [XLEN-1:0] b_data,
  // register file write port
  output logic            rf_enable,
  output logic [AW-1:0]   rf_rd_addr,
  output logic [XLEN-1:0] rf_write_data,
  // bypass lookups
  input  logic [AW-1:0]   q1_addr,
  output logic            q1_hit,
  output logic [XLEN-1:0] q1_data,
  input  logic [AW-1:0]   q2_addr,
  output logic            q2_hit,
  output logic [XLEN-1:0] q2_data,
  // occupancy
  output logic [CW-1:0]   count,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [CW-1:0] w_count;
  logic          w_b_acc;
  logic          w_a_acc;
  logic          w_b_push;
  logic          w_a_push;
  logic          w_pop;
  logic [1:0]    w_pushes;
  logic [PW-1:0] w_a_slot;
  entry_t        w_head;

  // While reset is asserted the buffer already looks empty, so the drain,
  // bypass and readys all see a zero occupancy in that cycle.
  assign w_count = reset ? '0 : r_count;

  // Readys never credit the same-cycle drain and never look at rd.
  assign b_ready = (w_count < CW'(DEPTH));
  assign w_b_acc = b_valid & b_ready;
  assign a_ready = (({1'b0, w_count} + (CW+1)'(w_b_acc)) < (CW+1)'(DEPTH));
  assign w_a_acc = a_valid & a_ready;

  // Writes to x0 complete the handshake but never occupy a slot.
  assign w_b_push = w_b_acc & (b_rd != '0);
  assign w_a_push = w_a_acc & (a_rd != '0);
  assign w_pushes = {1'b0, w_b_push} + {1'b0, w_a_push};

  // B is older than A in a same-cycle pair, so A lands one slot after B.
  assign w_a_slot = r_tail + PW'(w_b_push);

  // The register file has no backpressure: the head pops on every busy edge.
  assign w_pop = (r_count != '0);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) r_head <= r_head + PW'(1);
      r_tail  <= r_tail + PW'(w_pushes);
      r_count <= r_count - CW'(w_pop) + CW'(w_pushes);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is intentionally not reset; occupancy lives only in
    // r_count and the pointers, so stale contents are never observed.
    if (w_b_push) r_mem[r_tail]   <= '{rd: b_rd, data: b_data};
    if (w_a_push) r_mem[w_a_slot] <= '{rd: a_rd, data: a_data};
  end

  // Drain port: the head entry is presented combinationally while non-empty.
  assign w_head        = r_mem[r_head];
  assign rf_enable     = (w_count != '0);
  assign rf_rd_addr    = rf_enable ? w_head.rd   : '0;
  assign rf_write_data = rf_enable ? w_head.data : '0;

  assign count = w_count;
  assign empty = (w_count == '0);

  // Scan occupied entries oldest to youngest; the last match is the youngest.
  function automatic logic [XLEN:0] lookup(input logic [AW-1:0] addr);
    logic [PW-1:0]   idx;
    logic            hit;
    logic [XLEN-1:0] data;
    // NOTE: defaults first so every path assigns every result (no latches).
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_head + PW'(i);
      if ((CW'(i) < w_count) && (addr != '0) && (r_mem[idx].rd == addr)) begin
        hit  = 1'b1;
        data = r_mem[idx].data;
      end
    end
    return {hit, data};
  endfunction

  // Bypass lookups for rs1 and rs2.
  always_comb begin
    {q1_hit, q1_data} = lookup(q1_addr);
    {q2_hit, q2_data} = lookup(q2_addr);
  end

endmodule
